// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port data memory: core vs loader, round-robin
// on ties, one fixed-latency transaction (IDLE->ISSUE->WAIT->DONE) per grant.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic              last_ldr_q, last_ldr_d;
  logic              win_ldr_q, win_ldr_d;
  logic              we_q, we_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              core_ack_q, core_ack_d;
  logic              ldr_ack_q, ldr_ack_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic              busy_q, busy_d;
  logic              pick_ldr;

  always_comb begin
    state_d      = state_q;
    last_ldr_d   = last_ldr_q;
    win_ldr_d    = win_ldr_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_ack_d   = 1'b0;
    ldr_ack_d    = 1'b0;
    core_rdata_d = core_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    // loader wins if alone, or on a tie when the core won last time
    pick_ldr     = ldr_req && (!core_req || !last_ldr_q);

    case (state_q)
      IDLE: begin
        if (core_req || ldr_req) begin
          win_ldr_d   = pick_ldr;
          last_ldr_d  = pick_ldr;
          we_d        = pick_ldr ? ldr_we    : core_we;
          mem_addr_d  = pick_ldr ? ldr_addr  : core_addr;
          mem_wdata_d = pick_ldr ? ldr_wdata : core_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (win_ldr_q) ldr_rdata_d  = mem_rdata;
            else           core_rdata_d = mem_rdata;
          end
          core_ack_d = !win_ldr_q;
          ldr_ack_d  = win_ldr_q;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_ldr_q   <= 1'b1;
      win_ldr_q    <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= 4'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_ack_q   <= 1'b0;
      ldr_ack_q    <= 1'b0;
      core_rdata_q <= '0;
      ldr_rdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_ldr_q   <= last_ldr_d;
      win_ldr_q    <= win_ldr_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_ack_q   <= core_ack_d;
      ldr_ack_q    <= ldr_ack_d;
      core_rdata_q <= core_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_ack   = core_ack_q;
  assign ldr_ack    = ldr_ack_q;
  assign core_rdata = core_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and 3), each with a memory model
// and a transaction-phase reference model; directed scenarios then random traffic.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        core_req[2], core_we[2], ldr_req[2], ldr_we[2];
  logic [31:0] core_addr[2], core_wdata[2], ldr_addr[2], ldr_wdata[2];
  logic [31:0] core_rdata[2], ldr_rdata[2];
  logic        core_ack[2], ldr_ack[2];
  logic        mem_en[2], mem_we[2], busy[2];
  logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .core_req(core_req[0]), .core_we(core_we[0]), .core_addr(core_addr[0]),
    .core_wdata(core_wdata[0]), .core_rdata(core_rdata[0]), .core_ack(core_ack[0]),
    .ldr_req(ldr_req[0]), .ldr_we(ldr_we[0]), .ldr_addr(ldr_addr[0]),
    .ldr_wdata(ldr_wdata[0]), .ldr_rdata(ldr_rdata[0]), .ldr_ack(ldr_ack[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0]));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .core_req(core_req[1]), .core_we(core_we[1]), .core_addr(core_addr[1]),
    .core_wdata(core_wdata[1]), .core_rdata(core_rdata[1]), .core_ack(core_ack[1]),
    .ldr_req(ldr_req[1]), .ldr_we(ldr_we[1]), .ldr_addr(ldr_addr[1]),
    .ldr_wdata(ldr_wdata[1]), .ldr_rdata(ldr_rdata[1]), .ldr_ack(ldr_ack[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1]));

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  function automatic int lat(int l);
    return (l == 0) ? 1 : 3;
  endfunction

  // ---------------- memory: write at mem_en, read data appears MEM_LAT cycles later
  logic [31:0] mem_arr[2][256];
  logic [31:0] stg[2][3];

  initial forever begin
    @(posedge clk);
    for (int l = 0; l < 2; l++) begin
      for (int s = 2; s > 0; s--) stg[l][s] = stg[l][s-1];
      stg[l][0] = $urandom;
      if (mem_en[l] === 1'b1) begin
        if (mem_we[l]) mem_arr[l][mem_addr[l][9:2]] = mem_wdata[l];
        else           stg[l][0] = mem_arr[l][mem_addr[l][9:2]];
      end
      mem_rdata[l] <= stg[l][lat(l)-1];
    end
  end

  // ---------------- reference model: phase counts cycles since grant (0 = idle)
  logic [31:0] shd[2][256];
  int          ph[2];
  bit          win[2], lastw[2], twe[2];
  logic [31:0] tad[2], twd[2];
  logic        e_en[2], e_we[2], e_cack[2], e_lack[2], e_busy[2];
  logic [31:0] e_ad[2], e_wd[2], e_crd[2], e_lrd[2];

  initial forever begin
    @(posedge clk or posedge rst);
    for (int l = 0; l < 2; l++) begin
      if (rst) begin
        ph[l] = 0; lastw[l] = 1'b1; win[l] = 1'b0; twe[l] = 1'b0;
        e_en[l] = 0; e_we[l] = 0; e_cack[l] = 0; e_lack[l] = 0; e_busy[l] = 0;
        e_ad[l] = 0; e_wd[l] = 0; e_crd[l] = 0; e_lrd[l] = 0;
      end else begin
        if (ph[l] == 0) begin
          if (core_req[l] || ldr_req[l]) begin
            win[l]   = (core_req[l] && ldr_req[l]) ? !lastw[l] : ldr_req[l];
            lastw[l] = win[l];
            twe[l]   = win[l] ? ldr_we[l]    : core_we[l];
            tad[l]   = win[l] ? ldr_addr[l]  : core_addr[l];
            twd[l]   = win[l] ? ldr_wdata[l] : core_wdata[l];
            if (twe[l]) shd[l][tad[l][9:2]] = twd[l];
            ph[l] = 1;
          end
        end else begin
          ph[l]++;
          if (ph[l] > lat(l) + 2) ph[l] = 0;
        end
        if (ph[l] == lat(l) + 2 && !twe[l]) begin
          if (win[l]) e_lrd[l] = shd[l][tad[l][9:2]];
          else        e_crd[l] = shd[l][tad[l][9:2]];
        end
        e_en[l] = (ph[l] == 1);
        e_we[l] = (ph[l] == 1) && twe[l];
        if (ph[l] == 1) begin
          e_ad[l] = tad[l];
          e_wd[l] = twd[l];
        end
        e_cack[l] = (ph[l] == lat(l) + 2) && !win[l];
        e_lack[l] = (ph[l] == lat(l) + 2) && win[l];
        e_busy[l] = (ph[l] != 0);
      end
    end
  end

  // ---------------- per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      for (int l = 0; l < 2; l++) begin
        logic [132:0] got, want;
        got  = {mem_en[l], mem_we[l], mem_addr[l], mem_wdata[l], core_ack[l], ldr_ack[l],
                core_rdata[l], ldr_rdata[l], busy[l]};
        want = {e_en[l], e_we[l], e_ad[l], e_wd[l], e_cack[l], e_lack[l],
                e_crd[l], e_lrd[l], e_busy[l]};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL model lane%0d t=%0t got=%h want=%h", l, $time, got, want);
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic set_core(int l, logic r, logic we, logic [31:0] a, logic [31:0] d);
    core_req[l] = r; core_we[l] = we; core_addr[l] = a; core_wdata[l] = d;
  endtask

  task automatic set_ldr(int l, logic r, logic we, logic [31:0] a, logic [31:0] d);
    ldr_req[l] = r; ldr_we[l] = we; ldr_addr[l] = a; ldr_wdata[l] = d;
  endtask

  task automatic chk_zero(int l, string nm);
    chk({nm, ".mem_en"},     32'(mem_en[l]),   0);
    chk({nm, ".mem_we"},     32'(mem_we[l]),   0);
    chk({nm, ".mem_addr"},   mem_addr[l],      0);
    chk({nm, ".mem_wdata"},  mem_wdata[l],     0);
    chk({nm, ".core_ack"},   32'(core_ack[l]), 0);
    chk({nm, ".ldr_ack"},    32'(ldr_ack[l]),  0);
    chk({nm, ".core_rdata"}, core_rdata[l],    0);
    chk({nm, ".ldr_rdata"},  ldr_rdata[l],     0);
    chk({nm, ".busy"},       32'(busy[l]),     0);
  endtask

  initial begin
    logic [31:0] r;
    for (int l = 0; l < 2; l++) begin
      set_core(l, 0, 0, 0, 0);
      set_ldr(l, 0, 0, 0, 0);
      mem_rdata[l] = 0;
      for (int i = 0; i < 256; i++) begin
        mem_arr[l][i] = 32'h5A00_0000 | (32'(l) << 12) | 32'(i);
        shd[l][i]     = mem_arr[l][i];
      end
      for (int s = 0; s < 3; s++) stg[l][s] = 0;
    end
    mem_arr[0][8'h40] = 32'hDEAD_BEEF;
    shd[0][8'h40]     = 32'hDEAD_BEEF;

    @(posedge clk);
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    // reset state
    chk_zero(0, "rst1");
    chk_zero(1, "rst3");
    rst = 1'b0;

    // single core read, MEM_LAT=1
    @(negedge clk); set_core(0, 1, 0, 32'h100, 0);
    @(negedge clk);
    chk("t1.mem_en", 32'(mem_en[0]), 1);
    chk("t1.mem_addr", mem_addr[0], 32'h100);
    chk("t1.busy", 32'(busy[0]), 1);
    @(negedge clk);
    chk("t1.ack_c2", 32'(core_ack[0]), 0);
    @(negedge clk);
    chk("t1.core_ack", 32'(core_ack[0]), 1);
    chk("t1.core_rdata", core_rdata[0], 32'hDEAD_BEEF);
    chk("t1.model_rdata", e_crd[0], 32'hDEAD_BEEF);
    chk("t1.ldr_ack", 32'(ldr_ack[0]), 0);
    set_core(0, 0, 0, 0, 0);

    // loader write then core read-back
    @(negedge clk);
    chk("t2.idle_busy", 32'(busy[0]), 0);
    set_ldr(0, 1, 1, 32'h104, 32'h1234_5678);
    @(negedge clk);
    chk("t2.mem_en", 32'(mem_en[0]), 1);
    chk("t2.mem_we", 32'(mem_we[0]), 1);
    chk("t2.mem_wdata", mem_wdata[0], 32'h1234_5678);
    chk("t2.mem_addr", mem_addr[0], 32'h104);
    @(negedge clk);
    chk("t2.ldr_ack_c2", 32'(ldr_ack[0]), 0);
    @(negedge clk);
    chk("t2.ldr_ack", 32'(ldr_ack[0]), 1);
    chk("t2.core_ack", 32'(core_ack[0]), 0);
    set_ldr(0, 0, 0, 0, 0);
    @(negedge clk); set_core(0, 1, 0, 32'h104, 0);
    repeat (3) @(negedge clk);
    chk("t2.rd_ack", 32'(core_ack[0]), 1);
    chk("t2.core_rdata", core_rdata[0], 32'h1234_5678);
    chk("t2.ldr_rdata_kept", ldr_rdata[0], 0);
    set_core(0, 0, 0, 0, 0);

    // continuous contention from reset release: core, ldr, core, ldr
    @(negedge clk);
    rst = 1'b1;
    set_core(0, 1, 0, 32'h100, 0);
    set_ldr(0, 1, 0, 32'h104, 0);
    @(negedge clk); rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk($sformatf("t3.core_ack_c%0d", c), 32'(core_ack[0]), 32'(c == 3 || c == 11));
      chk($sformatf("t3.ldr_ack_c%0d", c),  32'(ldr_ack[0]),  32'(c == 7 || c == 15));
    end
    set_core(0, 0, 0, 0, 0);
    set_ldr(0, 0, 0, 0, 0);

    // MEM_LAT=3 read; req held through DONE
    @(negedge clk); set_core(1, 1, 0, 32'h20, 0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("t4.mem_en_c%0d", c),   32'(mem_en[1]),   32'(c == 1));
      chk($sformatf("t4.core_ack_c%0d", c), 32'(core_ack[1]), 32'(c == 5));
      if (c == 5) chk("t4.core_rdata", core_rdata[1], 32'h5A00_1008);
      if (c == 6) set_core(1, 0, 0, 0, 0);
    end

    // reset during WAIT aborts the access
    @(negedge clk); set_core(0, 1, 0, 32'h100, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero(0, "t5.async");
    set_core(0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("t5.no_ack_c%0d", c), 32'(core_ack[0]), 0);
    end
    set_ldr(0, 1, 0, 32'h100, 0);
    repeat (3) @(negedge clk);
    chk("t5.ldr_ack", 32'(ldr_ack[0]), 1);
    chk("t5.ldr_rdata", ldr_rdata[0], 32'hDEAD_BEEF);
    set_ldr(0, 0, 0, 0, 0);
    @(negedge clk);
    set_core(0, 1, 0, 32'h104, 0);
    set_ldr(0, 1, 0, 32'h104, 0);
    repeat (3) @(negedge clk);
    chk("t5.tie_core_ack", 32'(core_ack[0]), 1);
    chk("t5.tie_ldr_ack", 32'(ldr_ack[0]), 0);
    set_core(0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("t5.tie_ldr_next", 32'(ldr_ack[0]), 1);
    set_ldr(0, 0, 0, 0, 0);

    // req dropped right after grant still completes
    @(negedge clk); set_core(0, 1, 0, 32'h104, 0);
    @(negedge clk); set_core(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("t6.core_ack", 32'(core_ack[0]), 1);
    chk("t6.core_rdata", core_rdata[0], 32'h1234_5678);

    // random traffic with occasional async reset
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        r = $urandom;
        set_core(l, $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), r & 32'hFFFF_FC3C, $urandom);
        r = $urandom;
        set_ldr(l, $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), r & 32'hFFFF_FC3C, $urandom);
      end
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
